div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 139 +++++++++++++
 tb/tb_div_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider, signed or unsigned, one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete on the start edge.
module div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign_mode,
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    output logic        busy,
    output logic        done,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        DivZero,
    output logic        Overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        qneg_q;
    logic        rneg_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;
    logic        divzero_q;
    logic        overflow_q;
    logic        done_q;

    logic        neg1_d;
    logic        neg2_d;
    logic [31:0] abs1_d;
    logic [31:0] abs2_d;
    logic        div0_d;
    logic        ovf_d;
    logic [32:0] shift_rem_d;
    logic [32:0] diff_d;
    logic [31:0] quo_fix_d;
    logic [31:0] rem_fix_d;

    // Magnitudes of the operands; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign neg1_d = sign_mode & In1[31];
    assign neg2_d = sign_mode & In2[31];
    assign abs1_d = neg1_d ? (~In1 + 32'd1) : In1;
    assign abs2_d = neg2_d ? (~In2 + 32'd1) : In2;
    assign div0_d = (In2 == 32'd0);
    assign ovf_d  = sign_mode && (In1 == 32'h8000_0000) && (In2 == 32'hFFFF_FFFF);

    // Partial remainder stays below the divisor, so the shifted value fits 33 bits and bit 32 of diff is its sign.
    assign shift_rem_d = {rem_q, quo_q[31]};
    assign diff_d      = shift_rem_d - {1'b0, dvs_q};

    assign quo_fix_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix_d = rneg_q ? (~rem_q + 32'd1) : rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            cnt_q       <= 5'd0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            divzero_q   <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divzero_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        if (div0_d) begin
                            quotient_q  <= 32'hFFFF_FFFF;
                            remainder_q <= In1;
                            divzero_q   <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else if (ovf_d) begin
                            quotient_q  <= 32'h8000_0000;
                            remainder_q <= 32'd0;
                            overflow_q  <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= 32'd0;
                            quo_q   <= abs1_d;
                            dvs_q   <= abs2_d;
                            qneg_q  <= neg1_d ^ neg2_d;
                            rneg_q  <= neg1_d;
                            cnt_q   <= 5'd0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo_q <= {quo_q[30:0], ~diff_d[32]};
                    rem_q <= diff_d[32] ? shift_rem_d[31:0] : diff_d[31:0];
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q  <= quo_fix_d;
                    remainder_q <= rem_fix_d;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Quotient  = quotient_q;
    assign Remainder = remainder_q;
    assign DivZero   = divzero_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, random vectors against a reference model,
// and hand-written sequences for start-during-done and reset-during-calculation.
module tb_div_seq;

    typedef struct packed {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        logic [7:0]  lat;
        logic [31:0] sc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sign_mode;
    logic [31:0] In1;
    logic [31:0] In2;
    logic        busy;
    logic        done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivZero;
    logic        Overflow;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    vec_t sb_q[$];
    vec_t tbl[13];

    div_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign_mode (sign_mode),
        .In1       (In1),
        .In2       (In2),
        .busy      (busy),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] q, input logic [31:0] r,
                                input logic dz, input logic ov, input logic [7:0] lat);
        vec_t v;
        v.s = s; v.a = a; v.b = b; v.q = q; v.r = r;
        v.dz = dz; v.ov = ov; v.lat = lat; v.sc = 32'd0;
        return v;
    endfunction

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic vec_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = a;
        sbv = b;
        if (b == 32'd0)
            return mk(s, a, b, 32'hFFFF_FFFF, a, 1'b1, 1'b0, 8'd1);
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return mk(s, a, b, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 8'd1);
        if (s) begin
            sq = sa / sbv;
            sr = sa % sbv;
            return mk(s, a, b, sq, sr, 1'b0, 1'b0, 8'd34);
        end
        return mk(s, a, b, a / b, a % b, 1'b0, 1'b0, 8'd34);
    endfunction

    // Monitor: counts edges and checks every done pulse against the scoreboard head.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 at edge %0d, expected no pulse", cyc);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn s=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dz=%0d ov=%0d lat=%0d",
                             e.s, e.a, e.b, Quotient, Remainder, DivZero, Overflow, cyc - int'(e.sc) + 1);
                    chk("quotient", Quotient, e.q);
                    chk("remainder", Remainder, e.r);
                    chk("divzero", {31'd0, DivZero}, {31'd0, e.dz});
                    chk("overflow", {31'd0, Overflow}, {31'd0, e.ov});
                    chk("latency", cyc - int'(e.sc) + 1, {24'd0, e.lat});
                end
            end
        end
    end

    task automatic wait_empty();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected %0d pending", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        sign_mode = v.s;
        In1 = v.a;
        In2 = v.b;
        start = 1'b1;
        v.sc = cyc + 1;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_empty();
        repeat (3) @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("quotient_held", Quotient, v.q);
        chk("remainder_held", Remainder, v.r);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        start = 1'b0;
        sign_mode = 1'b0;
        In1 = 32'd0;
        In2 = 32'd0;

        tbl[0]  = mk(1'b1, 32'd100,         32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 8'd34);
        tbl[1]  = mk(1'b1, 32'hFFFF_FF9C,   32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 1'b0, 8'd34);
        tbl[2]  = mk(1'b1, 32'd100,         32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 1'b0, 8'd34);
        tbl[3]  = mk(1'b1, 32'hFFFF_FF9C,   32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0, 8'd34);
        tbl[4]  = mk(1'b0, 32'hFFFF_FFFF,   32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 8'd34);
        tbl[5]  = mk(1'b1, 32'hFFFF_FFFF,   32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0, 8'd34);
        tbl[6]  = mk(1'b1, 32'd7,           32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 1'b0, 8'd1);
        tbl[7]  = mk(1'b0, 32'd7,           32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 1'b0, 8'd1);
        tbl[8]  = mk(1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1, 8'd1);
        tbl[9]  = mk(1'b0, 32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0, 8'd34);
        tbl[10] = mk(1'b0, 32'd5,           32'd9,          32'd0,          32'd5,          1'b0, 1'b0, 8'd34);
        tbl[11] = mk(1'b1, 32'hFFFF_FFF9,   32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0, 8'd1);
        tbl[12] = mk(1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0, 8'd34);

        #2;
        chk("reset_quotient", Quotient, 32'd0);
        chk("reset_remainder", Remainder, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i]);
        end

        for (int i = 0; i < 8; i++) begin
            logic s;
            logic [31:0] a;
            logic [31:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_vec(model(s, a, b));
        end

        // Start held through the done cycle: ignored there, accepted one cycle later.
        @(negedge clk);
        sign_mode = 1'b0;
        In1 = 32'd7;
        In2 = 32'd0;
        start = 1'b1;
        v = tbl[7];
        v.sc = cyc + 1;
        sb_q.push_back(v);
        @(negedge clk);
        chk("done_pulse_cycle", {31'd0, done}, 32'd1);
        In1 = 32'd20;
        In2 = 32'd6;
        @(negedge clk);
        v = mk(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0, 8'd34);
        v.sc = cyc + 1;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (2) @(negedge clk);

        // Reset in the middle of a calculation, with an ignored re-start before it.
        @(negedge clk);
        sign_mode = 1'b1;
        In1 = 32'd100;
        In2 = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        In1 = 32'd9;
        In2 = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_calc", {31'd0, busy}, 32'd1);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_quotient", Quotient, 32'd0);
        chk("async_rst_remainder", Remainder, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_flags", {30'd0, DivZero, Overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", Quotient, 32'd0);
        run_vec(mk(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 8'd34));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
